// File: rtl/key_mode_ctrl.sv
// Traffic-light front end: synchronises and debounces four active-low keys, turns
// presses into one-cycle flags and drives the registered operating mode, step and flash.
module key_mode_ctrl #(
  parameter int DEB_CNT   = 1_000_000,
  parameter int FLASH_CNT = 25_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key,
  output logic [3:0] key_flag,
  output logic [1:0] mode,
  output logic       step,
  output logic       flash,
  output logic       disp_en
);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    ALL_RED = 2'd1,
    NIGHT   = 2'd2,
    MANUAL  = 2'd3
  } mode_e;

  localparam int DW = $clog2(DEB_CNT);
  localparam int FW = $clog2(FLASH_CNT);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CNT - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CNT - 1);

  logic [3:0]    key_m;
  logic [3:0]    key_s;
  logic [3:0]    stable;
  logic [3:0]    stable_d;
  logic [DW-1:0] deb_cnt [4];
  logic [FW-1:0] flash_cnt;
  mode_e         mode_q;
  mode_e         next_mode;

  // Two-stage synchroniser; idles at 1 so a key held through reset still debounces.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_m <= 4'hF;
      key_s <= 4'hF;
    end else begin
      key_m <= key;
      key_s <= key_m;
    end
  end

  // Per-key debounce: the window restarts whenever the input agrees with stable again.
  // NOTE: the four counters are plain registers, not a RAM, so resetting them is legal and cheap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stable <= 4'hF;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (key_s[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= key_s[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stable_d <= 4'hF;
      key_flag <= 4'h0;
    end else begin
      stable_d <= stable;
      key_flag <= stable_d & ~stable;
    end
  end

  // Lower key index wins when flags coincide; ALL_RED only listens to key 0.
  // NOTE: next_mode gets a default first so no path through this block infers a latch.
  always_comb begin
    next_mode = mode_q;
    if (key_flag[0]) begin
      next_mode = (mode_q == ALL_RED) ? NORMAL : ALL_RED;
    end else if (key_flag[1]) begin
      if (mode_q == NIGHT)        next_mode = NORMAL;
      else if (mode_q != ALL_RED) next_mode = NIGHT;
    end else if (key_flag[2]) begin
      if (mode_q == MANUAL)       next_mode = NORMAL;
      else if (mode_q != ALL_RED) next_mode = MANUAL;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q  <= NORMAL;
      step    <= 1'b0;
      disp_en <= 1'b1;
    end else begin
      mode_q  <= next_mode;
      step    <= key_flag[3] && (mode_q == MANUAL) && (key_flag[2:0] == 3'b000);
      disp_en <= (next_mode == NORMAL) || (next_mode == MANUAL);
    end
  end

  assign mode = mode_q;

  // Blink phase starts lit on NIGHT entry and is forced dark the moment NIGHT is left.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flash_cnt <= '0;
      flash     <= 1'b0;
    end else if (next_mode != NIGHT) begin
      flash_cnt <= '0;
      flash     <= 1'b0;
    end else if (mode_q != NIGHT) begin
      flash_cnt <= '0;
      flash     <= 1'b1;
    end else if (flash_cnt == FLASH_LAST) begin
      flash_cnt <= '0;
      flash     <= ~flash;
    end else begin
      flash_cnt <= flash_cnt + FW'(1);
    end
  end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Bench for key_mode_ctrl: directed scenarios plus a randomised run compared cycle by
// cycle against a behavioural model of the debounce, mode rules and blink timing.
module tb_key_mode_ctrl;

  localparam int DEB   = 4;
  localparam int FLASH = 8;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key       = 4'hF;
  logic [3:0] key_flag;
  logic [1:0] mode;
  logic       step;
  logic       flash;
  logic       disp_en;

  int n_checks = 0;
  int n_pass   = 0;

  key_mode_ctrl #(.DEB_CNT(DEB), .FLASH_CNT(FLASH)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .key_flag (key_flag),
    .mode     (mode),
    .step     (step),
    .flash    (flash),
    .disp_en  (disp_en)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: raw key seen two edges late, flips after DEB consecutive
  // disagreeing edges, flag one edge after a fall, blink from time spent in NIGHT.
  logic [3:0] ks_pipe [2];
  int         run_len [4];
  logic [3:0] m_stable;
  logic [3:0] m_fell;
  logic [3:0] e_flag;
  logic [1:0] e_mode;
  logic       e_step;
  logic       e_flash;
  logic       e_disp;
  int         night_age;

  function automatic logic [1:0] mode_rule(input logic [1:0] cur, input logic [3:0] f);
    if (f[0]) return (cur == 2'd1) ? 2'd0 : 2'd1;
    if (f[1]) return (cur == 2'd1) ? cur : ((cur == 2'd2) ? 2'd0 : 2'd2);
    if (f[2]) return (cur == 2'd1) ? cur : ((cur == 2'd3) ? 2'd0 : 2'd3);
    return cur;
  endfunction

  task model_reset();
    ks_pipe[0] = 4'hF;
    ks_pipe[1] = 4'hF;
    for (int i = 0; i < 4; i++) run_len[i] = 0;
    m_stable  = 4'hF;
    m_fell    = 4'h0;
    e_flag    = 4'h0;
    e_mode    = 2'd0;
    e_step    = 1'b0;
    e_flash   = 1'b0;
    e_disp    = 1'b1;
    night_age = 0;
  endtask

  task model_edge();
    logic [1:0] nm;
    logic [3:0] ks;
    nm      = mode_rule(e_mode, e_flag);
    e_step  = e_flag[3] && (e_mode == 2'd3) && (e_flag[2:0] == 3'b000);
    e_disp  = (nm == 2'd0) || (nm == 2'd3);
    if (nm == 2'd2) night_age = (e_mode == 2'd2) ? night_age + 1 : 0;
    else            night_age = 0;
    e_flash = (nm == 2'd2) && (((night_age / FLASH) % 2) == 0);
    e_mode  = nm;
    e_flag  = m_fell;
    ks      = ks_pipe[1];
    m_fell  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (ks[i] != m_stable[i]) begin
        run_len[i]++;
        if (run_len[i] == DEB) begin
          m_fell[i]   = (ks[i] == 1'b0);
          m_stable[i] = ks[i];
          run_len[i]  = 0;
        end
      end else begin
        run_len[i] = 0;
      end
    end
    ks_pipe[1] = ks_pipe[0];
    ks_pipe[0] = key;
  endtask

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) model_reset();
    else            model_edge();
  end

  task automatic wait_flag(input int idx, input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge sys_clk);
      if (key_flag[idx]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic press_key(input int idx);
    int lat;
    key[idx] = 1'b0;
    wait_flag(idx, 30, lat);
    @(negedge sys_clk);
  endtask

  task automatic release_keys();
    key = 4'hF;
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    key       = 4'hF;
    repeat (3) @(negedge sys_clk);
    n_checks++; if (key_flag !== 4'h0) $display("FAIL reset_flag: got %b want 0000", key_flag); else n_pass++;
    n_checks++; if (mode !== 2'd0) $display("FAIL reset_mode: got %0d want 0", mode); else n_pass++;
    n_checks++; if (step !== 1'b0) $display("FAIL reset_step: got %b want 0", step); else n_pass++;
    n_checks++; if (flash !== 1'b0) $display("FAIL reset_flash: got %b want 0", flash); else n_pass++;
    n_checks++; if (disp_en !== 1'b1) $display("FAIL reset_disp: got %b want 1", disp_en); else n_pass++;
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_bounce();
    int lat;
    key[0] = 1'b0;
    repeat (3) @(negedge sys_clk);
    key[0] = 1'b1;
    @(negedge sys_clk);
    key[0] = 1'b0;
    wait_flag(0, 30, lat);
    n_checks++; if (lat != 7) $display("FAIL bounce_latency: got %0d want 7", lat); else n_pass++;
    n_checks++; if (key_flag !== 4'b0001) $display("FAIL bounce_flag: got %b want 0001", key_flag); else n_pass++;
    @(negedge sys_clk);
    n_checks++; if (key_flag !== 4'h0) $display("FAIL bounce_pulse_width: got %b want 0000", key_flag); else n_pass++;
    n_checks++; if (mode !== 2'd1) $display("FAIL bounce_mode: got %0d want 1", mode); else n_pass++;
    n_checks++; if (disp_en !== 1'b0) $display("FAIL bounce_disp: got %b want 0", disp_en); else n_pass++;
    key = 4'hF;
    repeat (12) @(negedge sys_clk);
    n_checks++; if (mode !== 2'd1) $display("FAIL release_no_flag: mode %0d want 1", mode); else n_pass++;
    press_key(0);
    n_checks++; if (mode !== 2'd0) $display("FAIL allred_exit_mode: got %0d want 0", mode); else n_pass++;
    n_checks++; if (disp_en !== 1'b1) $display("FAIL allred_exit_disp: got %b want 1", disp_en); else n_pass++;
    release_keys();
  endtask

  task automatic test_night();
    press_key(1);
    key = 4'hF;
    n_checks++; if (mode !== 2'd2) $display("FAIL night_mode: got %0d want 2", mode); else n_pass++;
    n_checks++; if (flash !== 1'b1) $display("FAIL night_entry_flash: got %b want 1", flash); else n_pass++;
    n_checks++; if (disp_en !== 1'b0) $display("FAIL night_disp: got %b want 0", disp_en); else n_pass++;
    repeat (7) @(negedge sys_clk);
    n_checks++; if (flash !== 1'b1) $display("FAIL flash_c7: got %b want 1", flash); else n_pass++;
    @(negedge sys_clk);
    n_checks++; if (flash !== 1'b0) $display("FAIL flash_c8: got %b want 0", flash); else n_pass++;
    repeat (7) @(negedge sys_clk);
    n_checks++; if (flash !== 1'b0) $display("FAIL flash_c15: got %b want 0", flash); else n_pass++;
    @(negedge sys_clk);
    n_checks++; if (flash !== 1'b1) $display("FAIL flash_c16: got %b want 1", flash); else n_pass++;
    press_key(1);
    n_checks++; if (mode !== 2'd0) $display("FAIL night_exit_mode: got %0d want 0", mode); else n_pass++;
    n_checks++; if (flash !== 1'b0) $display("FAIL night_exit_flash: got %b want 0", flash); else n_pass++;
    release_keys();
  endtask

  task automatic test_priority();
    int lat;
    key[1] = 1'b0;
    key[2] = 1'b0;
    wait_flag(1, 30, lat);
    n_checks++; if (key_flag !== 4'b0110) $display("FAIL prio12_flags: got %b want 0110", key_flag); else n_pass++;
    @(negedge sys_clk);
    n_checks++; if (mode !== 2'd2) $display("FAIL prio12_mode: got %0d want 2", mode); else n_pass++;
    release_keys();
    key[0] = 1'b0;
    key[2] = 1'b0;
    wait_flag(0, 30, lat);
    @(negedge sys_clk);
    n_checks++; if (mode !== 2'd1) $display("FAIL prio02_mode: got %0d want 1", mode); else n_pass++;
    release_keys();
    press_key(1);
    n_checks++; if (mode !== 2'd1) $display("FAIL allred_ignores_k1: got %0d want 1", mode); else n_pass++;
    release_keys();
    press_key(0);
    n_checks++; if (mode !== 2'd0) $display("FAIL prio_restore: got %0d want 0", mode); else n_pass++;
    release_keys();
  endtask

  task automatic test_manual();
    int steps;
    press_key(2);
    n_checks++; if (mode !== 2'd3) $display("FAIL manual_mode: got %0d want 3", mode); else n_pass++;
    n_checks++; if (disp_en !== 1'b1) $display("FAIL manual_disp: got %b want 1", disp_en); else n_pass++;
    release_keys();
    steps  = 0;
    key[3] = 1'b0;
    repeat (60) begin
      @(negedge sys_clk);
      if (step) steps++;
    end
    n_checks++; if (steps != 1) $display("FAIL manual_held_step: got %0d pulses want 1", steps); else n_pass++;
    release_keys();
    press_key(2);
    n_checks++; if (mode !== 2'd0) $display("FAIL manual_exit: got %0d want 0", mode); else n_pass++;
    release_keys();
    steps  = 0;
    key[3] = 1'b0;
    repeat (20) begin
      @(negedge sys_clk);
      if (step) steps++;
    end
    n_checks++; if (steps != 0) $display("FAIL normal_no_step: got %0d pulses want 0", steps); else n_pass++;
    release_keys();
  endtask

  task automatic test_reset_midop();
    int flags;
    press_key(1);
    key = 4'hF;
    repeat (5) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++; if (mode !== 2'd0) $display("FAIL midop_mode: got %0d want 0", mode); else n_pass++;
    n_checks++; if (flash !== 1'b0) $display("FAIL midop_flash: got %b want 0", flash); else n_pass++;
    n_checks++; if (disp_en !== 1'b1) $display("FAIL midop_disp: got %b want 1", disp_en); else n_pass++;
    key = 4'b1011;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    flags = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (key_flag[2]) flags++;
    end
    n_checks++; if (flags != 1) $display("FAIL held_through_reset_flags: got %0d want 1", flags); else n_pass++;
    n_checks++; if (mode !== 2'd3) $display("FAIL held_through_reset_mode: got %0d want 3", mode); else n_pass++;
    release_keys();
    press_key(2);
    release_keys();
  endtask

  task automatic test_random();
    logic [8:0] got;
    logic [8:0] want;
    int         bad;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge sys_clk);
      got  = {key_flag, mode, step, flash, disp_en};
      want = {e_flag, e_mode, e_step, e_flash, e_disp};
      n_checks++;
      if (got !== want) begin
        if (bad < 10) $display("FAIL random_c%0d: got %b want %b", c, got, want);
        bad++;
      end else begin
        n_pass++;
      end
      sys_rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) key[i] = ~key[i];
    end
    sys_rst_n = 1'b1;
    release_keys();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_night();
    test_priority();
    test_manual();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
